// File: rtl/pong_pkg.sv
// Shared encodings for the score display writer: FSM states, byte slots and
// the 7-segment (gfedcba) glyph constants.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_BIT     = 3'd2,
        ST_ACK     = 3'd3,
        ST_STOP    = 3'd4,
        ST_BUSFREE = 3'd5
    } state_t;

    localparam logic [2:0] BYTE_ADDR  = 3'd0;
    localparam logic [2:0] BYTE_INSTR = 3'd1;
    localparam logic [2:0] BYTE_CTRL  = 3'd2;
    localparam logic [2:0] BYTE_LEFT  = 3'd3;
    localparam logic [2:0] BYTE_RIGHT = 3'd4;

    localparam logic [7:0] INSTR_BYTE = 8'h00;

    localparam logic [7:0] SEG_0 = 8'h3F;
    localparam logic [7:0] SEG_1 = 8'h06;
    localparam logic [7:0] SEG_2 = 8'h5B;
    localparam logic [7:0] SEG_3 = 8'h4F;
    localparam logic [7:0] SEG_4 = 8'h66;
    localparam logic [7:0] SEG_5 = 8'h6D;
    localparam logic [7:0] SEG_6 = 8'h7D;
    localparam logic [7:0] SEG_7 = 8'h07;
    localparam logic [7:0] SEG_8 = 8'h7F;
    localparam logic [7:0] SEG_9 = 8'h6F;
    localparam logic [7:0] SEG_A = 8'h77;
    localparam logic [7:0] SEG_B = 8'h7C;
    localparam logic [7:0] SEG_C = 8'h39;
    localparam logic [7:0] SEG_D = 8'h5E;
    localparam logic [7:0] SEG_E = 8'h79;
    localparam logic [7:0] SEG_F = 8'h71;

endpackage

// File: rtl/i2c_score_writer_if.sv
// Score input and status/clock outputs of the score display writer.
interface i2c_score_writer_if;
    logic [7:0] score;
    logic       scl;
    logic       busy;
    logic       ack_error;

    modport master (input score, output scl, output busy, output ack_error);
    modport slave  (output score, input scl, input busy, input ack_error);
endinterface

// File: rtl/hex_to_7seg.sv
// Combinational hex digit to 7-segment pattern (gfedcba, bit 7 unused).
module hex_to_7seg
    import pong_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] segs_c
);

    always_comb begin
        segs_c = SEG_0;
        case (digit)
            4'h0: segs_c = SEG_0;
            4'h1: segs_c = SEG_1;
            4'h2: segs_c = SEG_2;
            4'h3: segs_c = SEG_3;
            4'h4: segs_c = SEG_4;
            4'h5: segs_c = SEG_5;
            4'h6: segs_c = SEG_6;
            4'h7: segs_c = SEG_7;
            4'h8: segs_c = SEG_8;
            4'h9: segs_c = SEG_9;
            4'hA: segs_c = SEG_A;
            4'hB: segs_c = SEG_B;
            4'hC: segs_c = SEG_C;
            4'hD: segs_c = SEG_D;
            4'hE: segs_c = SEG_E;
            4'hF: segs_c = SEG_F;
        endcase
    end

endmodule

// File: rtl/i2c_score_writer.sv
// Writes the two-digit score to an SAA1064-style display over I2C whenever
// the score differs from the last successfully written value.
module i2c_score_writer
    import pong_pkg::*;
#(
    parameter int unsigned SYS_CLK_MHZ = 100,
    parameter int unsigned SCL_KHZ     = 100,
    parameter logic [6:0]  DEV_ADDR    = 7'h38,
    parameter logic [7:0]  CTRL_BYTE   = 8'h47
) (
    input  logic                Clock,
    input  logic                Reset,
    i2c_score_writer_if.master  bus,
    inout  wire                 SDA
);

    localparam int unsigned QDIV = (SYS_CLK_MHZ * 1000) / (4 * SCL_KHZ);
    localparam int unsigned QW   = (QDIV > 1) ? $clog2(QDIV) : 1;

    logic [QW-1:0] qcnt;
    logic          tick_c;

    state_t     state, state_n;
    logic [1:0] qph, qph_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic [2:0] byte_idx, byte_idx_n;
    logic [7:0] snap, snap_n;
    logic [7:0] sent_score, sent_score_n;
    logic       sent_valid, sent_valid_n;
    logic       scl, scl_n;
    logic       sda_low, sda_low_n;
    logic       busy, busy_n;
    logic       ack_error, ack_error_n;
    logic       nacked, nacked_n;

    logic [7:0] seg_left_c, seg_right_c, cur_byte_c;
    logic       sda_in_c;

    hex_to_7seg u_seg_left  (.digit(snap[7:4]), .segs_c(seg_left_c));
    hex_to_7seg u_seg_right (.digit(snap[3:0]), .segs_c(seg_right_c));

    // Open-drain data line: only ever pulled low or released.
    assign SDA      = sda_low ? 1'b0 : 1'bz;
    assign sda_in_c = SDA;

    assign bus.scl       = scl;
    assign bus.busy      = busy;
    assign bus.ack_error = ack_error;

    // Quarter-bit tick generator.
    assign tick_c = (qcnt == QW'(QDIV - 1));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            qcnt <= '0;
        end else if (tick_c) begin
            qcnt <= '0;
        end else begin
            qcnt <= qcnt + QW'(1);
        end
    end

    always_comb begin
        cur_byte_c = {DEV_ADDR, 1'b0};
        case (byte_idx)
            BYTE_ADDR:  cur_byte_c = {DEV_ADDR, 1'b0};
            BYTE_INSTR: cur_byte_c = INSTR_BYTE;
            BYTE_CTRL:  cur_byte_c = CTRL_BYTE;
            BYTE_LEFT:  cur_byte_c = seg_left_c;
            BYTE_RIGHT: cur_byte_c = seg_right_c;
            default:    cur_byte_c = {DEV_ADDR, 1'b0};
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= ST_IDLE;
            qph        <= 2'd0;
            bit_idx    <= 3'd7;
            byte_idx   <= BYTE_ADDR;
            snap       <= 8'h00;
            sent_score <= 8'h00;
            sent_valid <= 1'b0;
            scl        <= 1'b1;
            sda_low    <= 1'b0;
            busy       <= 1'b0;
            ack_error  <= 1'b0;
            nacked     <= 1'b0;
        end else begin
            state      <= state_n;
            qph        <= qph_n;
            bit_idx    <= bit_idx_n;
            byte_idx   <= byte_idx_n;
            snap       <= snap_n;
            sent_score <= sent_score_n;
            sent_valid <= sent_valid_n;
            scl        <= scl_n;
            sda_low    <= sda_low_n;
            busy       <= busy_n;
            ack_error  <= ack_error_n;
            nacked     <= nacked_n;
        end
    end

    // Bus sequencing; every line change is gated by the quarter tick.
    always_comb begin
        state_n      = state;
        qph_n        = qph;
        bit_idx_n    = bit_idx;
        byte_idx_n   = byte_idx;
        snap_n       = snap;
        sent_score_n = sent_score;
        sent_valid_n = sent_valid;
        scl_n        = scl;
        sda_low_n    = sda_low;
        busy_n       = busy;
        ack_error_n  = ack_error;
        nacked_n     = nacked;

        if (tick_c) begin
            case (state)
                ST_IDLE: begin
                    if (!sent_valid || (bus.score != sent_score)) begin
                        snap_n    = bus.score;
                        busy_n    = 1'b1;
                        sda_low_n = 1'b1;
                        state_n   = ST_START;
                    end
                end
                ST_START: begin
                    scl_n      = 1'b0;
                    qph_n      = 2'd0;
                    bit_idx_n  = 3'd7;
                    byte_idx_n = BYTE_ADDR;
                    nacked_n   = 1'b0;
                    state_n    = ST_BIT;
                end
                ST_BIT: begin
                    qph_n = qph + 2'd1;
                    case (qph)
                        2'd0: sda_low_n = ~cur_byte_c[bit_idx];
                        2'd1: scl_n = 1'b1;
                        2'd2: ;
                        2'd3: begin
                            scl_n = 1'b0;
                            if (bit_idx == 3'd0) begin
                                state_n = ST_ACK;
                            end else begin
                                bit_idx_n = bit_idx - 3'd1;
                            end
                        end
                    endcase
                end
                ST_ACK: begin
                    qph_n = qph + 2'd1;
                    case (qph)
                        2'd0: sda_low_n = 1'b0;
                        2'd1: scl_n = 1'b1;
                        2'd2: begin
                            if (sda_in_c) begin
                                nacked_n    = 1'b1;
                                ack_error_n = 1'b1;
                            end
                        end
                        2'd3: begin
                            scl_n = 1'b0;
                            if (nacked || (byte_idx == BYTE_RIGHT)) begin
                                state_n = ST_STOP;
                            end else begin
                                byte_idx_n = byte_idx + 3'd1;
                                bit_idx_n  = 3'd7;
                                state_n    = ST_BIT;
                            end
                        end
                    endcase
                end
                ST_STOP: begin
                    qph_n = qph + 2'd1;
                    case (qph)
                        2'd0: sda_low_n = 1'b1;
                        2'd1: scl_n = 1'b1;
                        default: begin
                            sda_low_n = 1'b0;
                            qph_n     = 2'd0;
                            state_n   = ST_BUSFREE;
                        end
                    endcase
                end
                ST_BUSFREE: begin
                    qph_n = qph + 2'd1;
                    if (qph == 2'd3) begin
                        busy_n  = 1'b0;
                        state_n = ST_IDLE;
                        // A NACKed transfer leaves sent_valid alone so IDLE retries it.
                        if (!nacked) begin
                            sent_score_n = snap;
                            sent_valid_n = 1'b1;
                            ack_error_n  = 1'b0;
                        end
                    end
                end
                default: begin
                    qph_n   = 2'd0;
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_score_writer.sv
// Scoreboard bench: an I2C bus monitor/slave decodes bytes and checks them
// against the expected display writes queued by each scenario.
module tb_i2c_score_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_score_writer_if bus();

    wire  sda;
    logic slave_low = 1'b0;
    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    i2c_score_writer #(
        .SYS_CLK_MHZ(100),
        .SCL_KHZ    (6250),
        .DEV_ADDR   (7'h38),
        .CTRL_BYTE  (8'h47)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .bus  (bus),
        .SDA  (sda)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] seg_tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    int   start_cnt = 0;
    int   stop_cnt = 0;
    int   last_tr_bytes = 0;
    int   bitcnt = 0;
    int   byte_in_tr = 0;
    logic in_tr = 1'b0;
    logic mon_en = 1'b0;
    logic nack_pending = 1'b0;
    logic prev_scl = 1'b1;
    logic prev_sda = 1'b1;
    logic prev_busy = 1'b0;
    logic [7:0] shreg = 8'h00;

    // Bus monitor, protocol checker and ACKing slave, sampled on the falling clock edge.
    initial begin
        logic sda_now, scl_now;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            sda_now = sda;
            scl_now = bus.scl;
            if (!mon_en) begin
                in_tr     = 1'b0;
                bitcnt    = 0;
                slave_low = 1'b0;
            end else begin
                if (sda_now != prev_sda) begin
                    total++;
                    if (scl_now != prev_scl) begin
                        bad++;
                        $display("FAIL sda_scl_same_edge: sda %b->%b with scl %b->%b, want scl steady",
                                 prev_sda, sda_now, prev_scl, scl_now);
                    end
                end
                if (scl_now && prev_scl && (sda_now != prev_sda)) begin
                    if (!sda_now) begin
                        total++;
                        if (prev_busy !== 1'b0) begin
                            bad++;
                            $display("FAIL start_while_busy: busy before START=%b want 0", prev_busy);
                        end
                        in_tr      = 1'b1;
                        bitcnt     = 0;
                        byte_in_tr = 0;
                        start_cnt++;
                    end else begin
                        last_tr_bytes = byte_in_tr;
                        in_tr         = 1'b0;
                        stop_cnt++;
                    end
                end
                if (scl_now && !prev_scl && in_tr) begin
                    total++;
                    if (bus.busy !== 1'b1) begin
                        bad++;
                        $display("FAIL busy_in_transfer: busy=%b want 1", bus.busy);
                    end
                    if (bitcnt < 8) begin
                        shreg = {shreg[6:0], sda_now};
                        bitcnt++;
                        if (bitcnt == 8) begin
                            total++;
                            if (exp_q.size() == 0) begin
                                bad++;
                                $display("FAIL unexpected_byte: got %h want none", shreg);
                            end else begin
                                e = exp_q.pop_front();
                                if (shreg !== e) begin
                                    bad++;
                                    $display("FAIL wire_byte: got %h want %h", shreg, e);
                                end
                            end
                        end
                    end else begin
                        bitcnt = 0;
                        byte_in_tr++;
                    end
                end
                if (!scl_now && prev_scl && in_tr) begin
                    if (bitcnt == 8) begin
                        if (nack_pending && (byte_in_tr == 0)) begin
                            nack_pending = 1'b0;
                            slave_low    = 1'b0;
                        end else begin
                            slave_low = 1'b1;
                        end
                    end else begin
                        slave_low = 1'b0;
                    end
                end
            end
            prev_scl  = scl_now;
            prev_sda  = sda_now;
            prev_busy = bus.busy;
        end
    end

    task automatic push_tr(input logic [7:0] s);
        exp_q.push_back(8'h70);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h47);
        exp_q.push_back(seg_tbl[s[7:4]]);
        exp_q.push_back(seg_tbl[s[3:0]]);
    endtask

    task automatic wait_stops(input int target, input string name);
        int n;
        n = 0;
        while ((stop_cnt < target) && (n < 5000)) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (stop_cnt < target) begin
            bad++;
            $display("FAIL %s_stop_timeout: stops=%0d want %0d", name, stop_cnt, target);
        end
        n = 0;
        while ((bus.busy === 1'b1) && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_busy_timeout: busy=%b want 0", name, bus.busy);
        end
    endtask

    task automatic test_reset();
        int base;
        rst       = 1'b1;
        mon_en    = 1'b0;
        bus.score = 8'h00;
        repeat (5) @(posedge clk);
        @(negedge clk);
        total += 4;
        if (bus.scl !== 1'b1) begin bad++; $display("FAIL reset_scl: got %b want 1", bus.scl); end
        if (sda !== 1'b1) begin bad++; $display("FAIL reset_sda: got %b want 1 (released)", sda); end
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        if (bus.ack_error !== 1'b0) begin bad++; $display("FAIL reset_ackerr: got %b want 0", bus.ack_error); end
        push_tr(8'h00);
        base   = stop_cnt;
        mon_en = 1'b1;
        rst    = 1'b0;
        wait_stops(base + 1, "reset");
        total += 3;
        if (bus.ack_error !== 1'b0) begin bad++; $display("FAIL first_ackerr: got %b want 0", bus.ack_error); end
        if (last_tr_bytes != 5) begin bad++; $display("FAIL first_bytes: got %0d want 5", last_tr_bytes); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL first_queue: left %0d want 0", exp_q.size()); end
    endtask

    task automatic test_score_change();
        int base, base_start;
        push_tr(8'h12);
        base       = stop_cnt;
        base_start = start_cnt;
        bus.score  = 8'h12;
        wait_stops(base + 1, "change");
        total += 2;
        if (exp_q.size() != 0) begin bad++; $display("FAIL change_queue: left %0d want 0", exp_q.size()); end
        if (bus.ack_error !== 1'b0) begin bad++; $display("FAIL change_ackerr: got %b want 0", bus.ack_error); end
        repeat (2000) @(negedge clk);
        total += 2;
        if (start_cnt != base_start + 1) begin
            bad++; $display("FAIL quiet_starts: got %0d want %0d", start_cnt, base_start + 1);
        end
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL quiet_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_nack();
        int base;
        nack_pending = 1'b1;
        exp_q.push_back(8'h70);
        push_tr(8'h34);
        base      = stop_cnt;
        bus.score = 8'h34;
        wait_stops(base + 1, "nack");
        total += 2;
        if (bus.ack_error !== 1'b1) begin bad++; $display("FAIL nack_ackerr: got %b want 1", bus.ack_error); end
        if (last_tr_bytes != 1) begin bad++; $display("FAIL nack_stop_after_addr: bytes=%0d want 1", last_tr_bytes); end
        wait_stops(base + 2, "retry");
        total += 3;
        if (bus.ack_error !== 1'b0) begin bad++; $display("FAIL retry_ackerr: got %b want 0", bus.ack_error); end
        if (last_tr_bytes != 5) begin bad++; $display("FAIL retry_bytes: got %0d want 5", last_tr_bytes); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL retry_queue: left %0d want 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int base, base_start, n;
        push_tr(8'h12);
        push_tr(8'h13);
        base       = stop_cnt;
        base_start = start_cnt;
        bus.score  = 8'h12;
        n = 0;
        while (!((start_cnt > base_start) && (byte_in_tr >= 2)) && (n < 3000)) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!((start_cnt > base_start) && (byte_in_tr >= 2))) begin
            bad++; $display("FAIL b2b_reach_byte2: starts=%0d bytes=%0d want byte 2", start_cnt, byte_in_tr);
        end
        bus.score = 8'h13;
        wait_stops(base + 2, "b2b");
        total += 3;
        if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_queue: left %0d want 0", exp_q.size()); end
        if (start_cnt != base_start + 2) begin
            bad++; $display("FAIL b2b_starts: got %0d want %0d", start_cnt, base_start + 2);
        end
        if (bus.ack_error !== 1'b0) begin bad++; $display("FAIL b2b_ackerr: got %b want 0", bus.ack_error); end
    endtask

    task automatic test_reset_mid();
        int base, base_start, n;
        exp_q.push_back(8'h70);
        base_start = start_cnt;
        bus.score  = 8'hAF;
        n = 0;
        while (!((start_cnt > base_start) && (byte_in_tr == 1) && (bitcnt == 4) && (bus.scl === 1'b1))
               && (n < 3000)) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 3000) begin
            bad++; $display("FAIL midreset_reach: bytes=%0d bits=%0d want byte 1 bit 3", byte_in_tr, bitcnt);
        end
        mon_en = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        total += 4;
        if (bus.scl !== 1'b1) begin bad++; $display("FAIL midreset_scl: got %b want 1", bus.scl); end
        if (sda !== 1'b1) begin bad++; $display("FAIL midreset_sda: got %b want 1 (released)", sda); end
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL midreset_queue: left %0d want 0", exp_q.size()); end
        repeat (3) @(negedge clk);
        push_tr(8'hAF);
        base   = stop_cnt;
        mon_en = 1'b1;
        rst    = 1'b0;
        wait_stops(base + 1, "after_reset");
        total += 3;
        if (exp_q.size() != 0) begin bad++; $display("FAIL after_reset_queue: left %0d want 0", exp_q.size()); end
        if (last_tr_bytes != 5) begin bad++; $display("FAIL after_reset_bytes: got %0d want 5", last_tr_bytes); end
        if (bus.ack_error !== 1'b0) begin bad++; $display("FAIL after_reset_ackerr: got %b want 0", bus.ack_error); end
    endtask

    initial begin
        test_reset();
        test_score_change();
        test_nack();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
